ram_fifo: RTL and testbench



---
 rtl/ram_fifo_pkg.sv | 7 +
 rtl/ram_fifo_block_ram.sv | 28 ++
 rtl/ram_fifo.sv | 65 ++++++
 tb/tb_ram_fifo.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_fifo_pkg.sv
// Shared widths for the RAM-backed byte FIFO; these must match block_RAM.
package ram_fifo_pkg;
  localparam int FIFO_DATA_W = 8;
  localparam int FIFO_ADDR_W = 4;
  localparam int FIFO_PTR_W  = FIFO_ADDR_W + 1;
  localparam int FIFO_DEPTH  = 1 << FIFO_ADDR_W;
endpackage

// File: rtl/ram_fifo_block_ram.sv
// Simple dual-port 16x8 RAM with a registered read port; inferred as block RAM.
module block_RAM
  import ram_fifo_pkg::*;
#(
  parameter string INIT_FILE = ""
) (
  input  logic                   clk,
  input  logic                   w_en,
  input  logic [FIFO_ADDR_W-1:0] w_addr,
  input  logic [FIFO_DATA_W-1:0] w_data,
  input  logic                   r_en,
  input  logic [FIFO_ADDR_W-1:0] r_addr,
  output logic [FIFO_DATA_W-1:0] r_data
);

  logic [FIFO_DATA_W-1:0] mem [FIFO_DEPTH];

  // Preloading is not supported here; a non-empty INIT_FILE is rejected at elaboration.
  if (INIT_FILE != "") begin : g_init_unsupported
    $error("block_RAM: INIT_FILE preload not supported");
  end

  always_ff @(posedge clk) begin
    if (w_en) mem[w_addr] <= w_data;
    if (r_en) r_data <= mem[r_addr];
  end

endmodule

// File: rtl/ram_fifo.sv
// 16x8 synchronous FIFO: pointer/occupancy/flag control around one block_RAM.
module ram_fifo
  import ram_fifo_pkg::*;
#(
  parameter int ALMOST_FULL_LVL = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [FIFO_DATA_W-1:0] wr_data,
  input  logic                   rd_en,
  output logic [FIFO_DATA_W-1:0] rd_data,
  output logic                   rd_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic [FIFO_PTR_W-1:0]  count,
  output logic                   overflow,
  output logic                   underflow
);

  logic [FIFO_PTR_W-1:0] wr_ptr;
  logic [FIFO_PTR_W-1:0] rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  assign full        = (count == FIFO_PTR_W'(FIFO_DEPTH));
  assign empty       = (count == '0);
  assign almost_full = (count >= FIFO_PTR_W'(ALMOST_FULL_LVL));

  // Flags come from registered state, so a full/empty FIFO always blocks one side.
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      count    <= count + FIFO_PTR_W'(wr_acc) - FIFO_PTR_W'(rd_acc);
      rd_valid <= rd_acc;
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end

  block_RAM #(
    .INIT_FILE("")
  ) u_ram (
    .clk    (clk),
    .w_en   (wr_acc & rst_n),
    .w_addr (wr_ptr[FIFO_ADDR_W-1:0]),
    .w_data (wr_data),
    .r_en   (rd_acc & rst_n),
    .r_addr (rd_ptr[FIFO_ADDR_W-1:0]),
    .r_data (rd_data)
  );

endmodule

// File: tb/tb_ram_fifo.sv
// Directed self-checking bench for ram_fifo.
module tb_ram_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_fifo #(.ALMOST_FULL_LVL(12)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .count(count), .overflow(overflow), .underflow(underflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (count !== 5'd0)    begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (empty !== 1'b1)    begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
    total++; if (full !== 1'b0)     begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
    total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL reset_afull got=%b exp=0", almost_full); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    total++; if (overflow !== 1'b0 || underflow !== 1'b0)
      begin bad++; $display("FAIL reset_sticky got=%b%b exp=00", overflow, underflow); end
  endtask

  task automatic test_basic();
    logic [7:0] vals [3] = '{8'h11, 8'h22, 8'h33};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = vals[i];
      step();
    end
    wr_en = 1'b0;
    total++; if (count !== 5'd3) begin bad++; $display("FAIL basic_count3 got=%0d exp=3", count); end
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (rd_valid !== 1'b1 || rd_data !== vals[i])
        begin bad++; $display("FAIL basic_read%0d got=%b/%h exp=1/%h", i, rd_valid, rd_data, vals[i]); end
      total++; if (count !== 5'(2 - i))
        begin bad++; $display("FAIL basic_count%0d got=%0d exp=%0d", i, count, 2 - i); end
    end
    rd_en = 1'b0;
    step();
    total++; if (empty !== 1'b1 || rd_valid !== 1'b0)
      begin bad++; $display("FAIL basic_end got=empty%b valid%b exp=1/0", empty, rd_valid); end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      step();
      total++; if (almost_full !== (i + 1 >= 12))
        begin bad++; $display("FAIL fill_afull%0d got=%b exp=%b", i, almost_full, (i + 1 >= 12)); end
    end
    total++; if (full !== 1'b1 || count !== 5'd16)
      begin bad++; $display("FAIL fill_full got=full%b count%0d exp=1/16", full, count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fill_ovf_early got=%b exp=0", overflow); end
    wr_data = 8'hFF;
    step();
    wr_en = 1'b0;
    total++; if (overflow !== 1'b1 || count !== 5'd16)
      begin bad++; $display("FAIL fill_overflow got=ovf%b count%0d exp=1/16", overflow, count); end
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      total++; if (rd_valid !== 1'b1 || rd_data !== 8'(i))
        begin bad++; $display("FAIL drain%0d got=%b/%h exp=1/%h", i, rd_valid, rd_data, 8'(i)); end
    end
    rd_en = 1'b0;
    total++; if (empty !== 1'b1 || overflow !== 1'b1)
      begin bad++; $display("FAIL drain_end got=empty%b ovf%b exp=1/1", empty, overflow); end
  endtask

  task automatic test_underflow();
    do_reset();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    total++; if (rd_valid !== 1'b0 || underflow !== 1'b1 || count !== 5'd0)
      begin bad++; $display("FAIL underflow got=valid%b udf%b count%0d exp=0/1/0", rd_valid, underflow, count); end
    wr_en = 1'b1; wr_data = 8'hAA;
    step();
    wr_en = 1'b0; rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    total++; if (rd_valid !== 1'b1 || rd_data !== 8'hAA || count !== 5'd0)
      begin bad++; $display("FAIL underflow_ptr got=%b/%h/%0d exp=1/aa/0", rd_valid, rd_data, count); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      step();
    end
    wr_data = 8'hEE; rd_en = 1'b1;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    total++; if (rd_valid !== 1'b1 || rd_data !== 8'h00)
      begin bad++; $display("FAIL simul_full_read got=%b/%h exp=1/00", rd_valid, rd_data); end
    total++; if (count !== 5'd15 || overflow !== 1'b1 || full !== 1'b0)
      begin bad++; $display("FAIL simul_full got=count%0d ovf%b full%b exp=15/1/0", count, overflow, full); end
    do_reset();
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h5C;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    total++; if (count !== 5'd1 || rd_valid !== 1'b0 || underflow !== 1'b1)
      begin bad++; $display("FAIL simul_empty got=count%0d valid%b udf%b exp=1/0/1", count, rd_valid, underflow); end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    total++; if (rd_valid !== 1'b1 || rd_data !== 8'h5C)
      begin bad++; $display("FAIL simul_empty_read got=%b/%h exp=1/5c", rd_valid, rd_data); end
  endtask

  task automatic test_wrap();
    int errs = 0;
    do_reset();
    wr_en = 1'b1; wr_data = 8'd0;
    step();
    rd_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      wr_data = 8'(k + 1);
      step();
      total++; if (rd_valid !== 1'b1 || rd_data !== 8'(k) || count !== 5'd1) begin
        bad++;
        $display("FAIL wrap%0d got=%b/%h/%0d exp=1/%h/1", k, rd_valid, rd_data, count, 8'(k));
      end
    end
    wr_en = 1'b0;
    step();
    rd_en = 1'b0;
    total++; if (rd_data !== 8'd40 || count !== 5'd0)
      begin bad++; $display("FAIL wrap_last got=%h/%0d exp=28/0", rd_data, count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h40 + i);
      step();
    end
    wr_en = 1'b0;
    total++; if (count !== 5'd7) begin bad++; $display("FAIL mid_count7 got=%0d exp=7", count); end
    rd_en = 1'b1; rst_n = 1'b0;
    step();
    rst_n = 1'b1; rd_en = 1'b0;
    total++; if (empty !== 1'b1 || count !== 5'd0 || rd_valid !== 1'b0)
      begin bad++; $display("FAIL mid_reset got=empty%b count%0d valid%b exp=1/0/0", empty, count, rd_valid); end
    wr_en = 1'b1; wr_data = 8'h5A;
    step();
    wr_en = 1'b0; rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    total++; if (rd_valid !== 1'b1 || rd_data !== 8'h5A)
      begin bad++; $display("FAIL mid_after got=%b/%h exp=1/5a", rd_valid, rd_data); end
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
    step();
    test_reset();
    test_basic();
    test_fill_overflow();
    test_underflow();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
